// File: rtl/imgproc_pkg.sv
// imgproc_pkg: shared constants and FSM state type for the greyscale + 3x3 convolution pipeline
package imgproc_pkg;
   localparam int COORD_W      = 11;
   localparam int DEF_IMG_W    = 640;
   localparam int DEF_IMG_H    = 480;
   localparam int DEF_PIPE_LAT = 3;
   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_e;
endpackage

// File: rtl/imgproc_seq_valid_delay.sv
// valid_delay: LAT-deep single-bit shift chain with synchronous clear
// Ports: clk/rst clock and async active-high reset, clr sync clear of all stages,
//        d bit entering the chain, q bit leaving it LAT clocks later
module valid_delay #(
   parameter int LAT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic d,
   output logic q
);
   logic [LAT-1:0] sr;
   always_ff @(posedge clk or posedge rst)
      if (rst) sr <= '0;
      else sr <= clr ? '0 : LAT'({sr, d});
   assign q = sr[LAT-1];
endmodule

// File: rtl/imgproc_seq.sv
// imgproc_seq: pixel position counting, output-valid qualification and frame-stable kernel direction
// Ports: iCLK/iRST clock and async active-high reset; iDVAL input pixel valid; iSOF start-of-frame resync;
//        iDIR_SEL requested direction; oVERTICAL applied direction; oDVAL output valid;
//        oX/oY position of next input pixel; oFRAME_DONE end-of-frame pulse; oSTATE FSM state
module imgproc_seq
   import imgproc_pkg::*;
#(
   parameter int IMG_W     = DEF_IMG_W,
   parameter int IMG_H     = DEF_IMG_H,
   parameter int FILL_ROWS = 2,
   parameter int FILL_COLS = 2,
   parameter int PIPE_LAT  = DEF_PIPE_LAT
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic               iDVAL,
   input  logic               iSOF,
   input  logic               iDIR_SEL,
   output logic               oVERTICAL,
   output logic               oDVAL,
   output logic [COORD_W-1:0] oX,
   output logic [COORD_W-1:0] oY,
   output logic               oFRAME_DONE,
   output logic [1:0]         oSTATE
);
   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_FILL  = FILL;
   localparam logic [1:0] S_RUN   = RUN;
   localparam logic [1:0] S_DRAIN = DRAIN;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);
   localparam logic [COORD_W-1:0] X_FILL = COORD_W'(FILL_COLS);
   localparam logic [COORD_W-1:0] Y_FILL = COORD_W'(FILL_ROWS);
   localparam int CW = $clog2(PIPE_LAT + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(PIPE_LAT - 1);
   logic x_end, eof, qual, drain_done;
   logic [CW-1:0] cnt;
   always_comb begin
      x_end       = oX == X_LAST;
      eof         = iDVAL && x_end && oY == Y_LAST;
      qual        = iDVAL && oY >= Y_FILL && oX >= X_FILL;
      // the drain counter is loaded with PIPE_LAT-1 so that zero coincides with the last output leaving
      drain_done  = oSTATE == S_DRAIN && cnt == '0;
      oFRAME_DONE = drain_done && !iSOF;
   end
   always_ff @(posedge iCLK or posedge iRST)
      if (iRST) begin
         oX <= '0;
         oY <= '0;
      end else if (iSOF) begin
         // a pixel arriving with SOF is the (0,0) pixel of the new frame
         oX <= COORD_W'(iDVAL);
         oY <= '0;
      end else if (iDVAL) begin
         oX <= x_end ? '0 : oX + 1'b1;
         oY <= x_end ? (oY == Y_LAST ? '0 : oY + 1'b1) : oY;
      end
   always_ff @(posedge iCLK or posedge iRST)
      if (iRST) begin
         oSTATE    <= S_IDLE;
         oVERTICAL <= 1'b0;
         cnt       <= '0;
      end else if (iSOF) begin
         oSTATE    <= S_FILL;
         oVERTICAL <= iDIR_SEL;
      end else if (oSTATE == S_IDLE && iDVAL) begin
         oSTATE    <= S_FILL;
         oVERTICAL <= iDIR_SEL;
      end else if (oSTATE == S_FILL && oX == '0 && oY == Y_FILL) begin
         oSTATE <= S_RUN;
      end else if (oSTATE == S_RUN && eof) begin
         oSTATE <= S_DRAIN;
         cnt    <= CNT_LOAD;
      end else if (drain_done) begin
         oSTATE    <= S_FILL;
         oVERTICAL <= iDIR_SEL;
      end else if (oSTATE == S_DRAIN) begin
         cnt <= cnt - 1'b1;
      end
   valid_delay #(.LAT(PIPE_LAT)) u_dly (
      .clk(iCLK),
      .rst(iRST),
      .clr(iSOF),
      .d  (qual),
      .q  (oDVAL)
   );
endmodule

// File: tb/tb_imgproc_seq.sv
// tb_imgproc_seq: randomized and directed checks of imgproc_seq against a pixel-index reference model
module tb_imgproc_seq;
   localparam int W = 8, H = 6, FR = 2, FC = 2, LAT = 3;
   logic iCLK, iRST, iDVAL, iSOF, iDIR_SEL;
   logic oVERTICAL, oDVAL, oFRAME_DONE;
   logic [10:0] oX, oY;
   logic [1:0] oSTATE;
   int n_chk, n_pass;
   int pix, st, drain, vert;
   bit qh[$];
   int step_n, n_val, n_done, first_val, done_at;

   imgproc_seq #(.IMG_W(W), .IMG_H(H), .FILL_ROWS(FR), .FILL_COLS(FC), .PIPE_LAT(LAT)) dut (
      .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iSOF(iSOF), .iDIR_SEL(iDIR_SEL),
      .oVERTICAL(oVERTICAL), .oDVAL(oDVAL), .oX(oX), .oY(oY),
      .oFRAME_DONE(oFRAME_DONE), .oSTATE(oSTATE)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (step %0d)", tag, got, exp, step_n);
   endtask

   task automatic model_reset();
      pix = 0; st = 0; drain = 0; vert = 0;
      qh = {};
      repeat (LAT) qh.push_back(1'b0);
      step_n = 0; n_val = 0; n_done = 0; first_val = -1; done_at = -1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_x"}, oX, 0);
      chk({tag, "_y"}, oY, 0);
      chk({tag, "_state"}, oSTATE, 0);
      chk({tag, "_vert"}, oVERTICAL, 0);
      chk({tag, "_dval"}, oDVAL, 0);
      chk({tag, "_done"}, oFRAME_DONE, 0);
   endtask

   // synchronous-looking entry: leaves time at posedge+1
   task automatic do_reset();
      iDVAL = 0; iSOF = 0; iDIR_SEL = 0;
      #2 iRST = 1'b1;
      #1 check_zero("rst");
      model_reset();
      @(posedge iCLK);
      #1 iRST = 1'b0;
   endtask

   task automatic step(input bit d, input bit s, input bit dir);
      bit e_done, qual, eof;
      iDVAL = d; iSOF = s; iDIR_SEL = dir;
      #1;
      e_done = st == 3 && drain == 0 && !s;
      chk("done", oFRAME_DONE, e_done);
      if (oFRAME_DONE) begin
         n_done++;
         done_at = step_n;
      end
      qual = d && (pix / W) >= FR && (pix % W) >= FC;
      eof = d && pix == W * H - 1;
      @(posedge iCLK);
      if (s) begin
         st = 1; vert = dir; pix = d ? 1 : 0;
         qh = {};
         repeat (LAT) qh.push_back(1'b0);
      end else begin
         qh.push_back(qual);
         void'(qh.pop_front());
         case (st)
            0: if (d) begin st = 1; vert = dir; end
            1: if (pix == FR * W) st = 2;
            2: if (eof) begin st = 3; drain = LAT - 1; end
            default: if (drain == 0) begin st = 1; vert = dir; end else drain--;
         endcase
         if (d) pix = (pix + 1) % (W * H);
      end
      #1;
      chk("x", oX, pix % W);
      chk("y", oY, pix / W);
      chk("state", oSTATE, st);
      chk("vert", oVERTICAL, vert);
      chk("dval", oDVAL, qh[0]);
      if (oDVAL) begin
         n_val++;
         if (first_val < 0) first_val = step_n;
      end
      step_n++;
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      iRST = 1'b1; iDVAL = 0; iSOF = 0; iDIR_SEL = 0;
      model_reset();
      repeat (2) @(posedge iCLK);
      #1;
      check_zero("por");
      iRST = 1'b0;

      // continuous frame: first output 3 clocks after pixel (2,2), 24 outputs, one done
      do_reset();
      for (int i = 0; i < 51; i++) step(i < 48, 0, 0);
      chk("t1_first", first_val, 20);
      chk("t1_count", n_val, 24);
      chk("t1_ndone", n_done, 1);
      chk("t1_done_at", done_at, 50);

      // alternating valid
      do_reset();
      for (int i = 0; i < 104; i++) step(i % 2 == 0, 0, 0);
      chk("t2_count", n_val, 24);

      // direction change mid-frame waits for the frame boundary
      do_reset();
      for (int i = 0; i < 70; i++) step(1, 0, i >= 27);
      chk("t3_done_at", done_at, 50);
      chk("t3_vert", oVERTICAL, 1);

      // SOF with a pixel at (4,3)
      do_reset();
      for (int i = 0; i < 28; i++) step(1, 0, 0);
      step(1, 1, 1);
      chk("t4_x", oX, 1);
      chk("t4_y", oY, 0);
      chk("t4_dval", oDVAL, 0);
      chk("t4_state", oSTATE, 1);
      for (int i = 0; i < 12; i++) step(1, 0, 0);
      chk("t4_ndone", n_done, 0);

      // async reset mid-RUN
      do_reset();
      for (int i = 0; i < 30; i++) step(1, 0, 0);
      chk("t5_run", oSTATE, 2);
      do_reset();
      step(0, 0, 1);
      chk("t5_idle", oSTATE, 0);
      step(1, 0, 1);
      chk("t5_fill", oSTATE, 1);

      // back-to-back frames with valid held through drain
      do_reset();
      for (int i = 0; i < 99; i++) step(i < 96, 0, $urandom_range(0, 1));
      chk("t6_count", n_val, 48);
      chk("t6_ndone", n_done, 2);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0, $urandom_range(0, 1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
